// File: rtl/stack_executor_if.sv
// Request/stack bus between a keypad decoder, the stack storage and the
// stack executor.
//   op_valid/op_code/digit/op_ready : operation request handshake
//   stack_top/stack_next/stack_count : current stack view supplied to executor
//   push/pop/write/value             : stack command strobes and write data
//   busy/error                       : executor status
// master = requester and stack side, slave = executor side.
interface stack_executor_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [3:0]       op_code;
  logic [3:0]       digit;
  logic             op_ready;
  logic [WIDTH-1:0] stack_top;
  logic [WIDTH-1:0] stack_next;
  logic [5:0]       stack_count;
  logic             push;
  logic             pop;
  logic             write;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic [1:0]       error;

  modport master (
    output op_valid, op_code, digit, stack_top, stack_next, stack_count,
    input  op_ready, push, pop, write, value, busy, error
  );

  modport slave (
    input  op_valid, op_code, digit, stack_top, stack_next, stack_count,
    output op_ready, push, pop, write, value, busy, error
  );
endinterface

// File: rtl/stack_executor.sv
// RPN calculator stack executor: accepts one keypad operation at a time,
// computes the result from the current top two stack entries and issues a
// single registered stack command (push / pop / write + value) in a COMMIT
// cycle. Signed division runs on an iterative restoring divider.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : request handshake, stack view, stack commands and status
module stack_executor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  stack_executor_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_DIGIT = 4'd0;
  localparam logic [3:0] OP_ENTER = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_NEG   = 4'd6;
  localparam logic [3:0] OP_DROP  = 4'd7;
  localparam logic [3:0] OP_CLEAR = 4'd8;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_FULL  = 2'b10;
  localparam logic [1:0] ERR_INV   = 2'b11;

  typedef enum logic [1:0] {IDLE, DIV, COMMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q;
  logic [CW-1:0]    cnt_q;

  logic             res_push_c, res_pop_c, res_write_c, go_div_c;
  logic [WIDTH-1:0] res_value_c;
  logic [1:0]       res_err_c;
  logic [WIDTH-1:0] t, n, t10_c, dig_c;
  logic             short_c;

  logic [WIDTH:0]   rem_sh_c, diff_c;
  logic [WIDTH-1:0] rem_nxt_c, quo_nxt_c;

  assign t       = bus.stack_top;
  assign n       = bus.stack_next;
  assign t10_c   = t * WIDTH'(10);
  assign dig_c   = WIDTH'(bus.digit);
  assign short_c = (bus.stack_count < 6'd2);

  // Result of the requested operation as seen at the accepting edge.
  always_comb begin
    res_push_c  = 1'b0;
    res_pop_c   = 1'b0;
    res_write_c = 1'b0;
    res_value_c = '0;
    res_err_c   = ERR_NONE;
    go_div_c    = 1'b0;
    case (bus.op_code)
      OP_DIGIT: begin
        if (bus.digit > 4'd9) res_err_c = ERR_INV;
        else begin
          res_write_c = 1'b1;
          res_value_c = t[WIDTH-1] ? (t10_c - dig_c) : (t10_c + dig_c);
        end
      end
      OP_ENTER: begin
        if (bus.stack_count == 6'(DEPTH)) res_err_c = ERR_FULL;
        else begin
          res_push_c  = 1'b1;
          res_value_c = t;
        end
      end
      OP_ADD, OP_SUB, OP_MUL: begin
        if (short_c) res_err_c = ERR_UNDER;
        else begin
          res_pop_c   = 1'b1;
          res_write_c = 1'b1;
          if (bus.op_code == OP_ADD)      res_value_c = n + t;
          else if (bus.op_code == OP_SUB) res_value_c = n - t;
          else                            res_value_c = n * t;
        end
      end
      OP_DIV: begin
        if (short_c)        res_err_c = ERR_UNDER;
        else if (t == '0)   res_err_c = ERR_INV;
        else                go_div_c  = 1'b1;
      end
      OP_NEG: begin
        res_write_c = 1'b1;
        res_value_c = '0 - t;
      end
      OP_DROP: begin
        if (short_c) res_err_c = ERR_UNDER;
        else         res_pop_c = 1'b1;
      end
      OP_CLEAR: res_write_c = 1'b1;
      default:  res_err_c   = ERR_INV;
    endcase
  end

  // One restoring-division step on magnitudes: shift in next dividend bit,
  // keep the trial subtraction when it does not go negative.
  always_comb begin
    rem_sh_c = {1'b0, rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    rem_sh_c[WIDTH] = rem_q[WIDTH-1];
    diff_c   = rem_sh_c - {1'b0, dvs_q};
    if (!diff_c[WIDTH]) begin
      rem_nxt_c = diff_c[WIDTH-1:0];
      quo_nxt_c = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt_c = rem_sh_c[WIDTH-1:0];
      quo_nxt_c = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered strobes and status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bus.op_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.push     <= 1'b0;
      bus.pop      <= 1'b0;
      bus.write    <= 1'b0;
      bus.value    <= '0;
      bus.error    <= ERR_NONE;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      neg_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            bus.op_ready <= 1'b0;
            bus.busy     <= 1'b1;
            bus.error    <= res_err_c;
            bus.push     <= res_push_c;
            bus.pop      <= res_pop_c;
            bus.write    <= res_write_c;
            bus.value    <= res_value_c;
            rem_q        <= '0;
            quo_q        <= n[WIDTH-1] ? ('0 - n) : n;
            dvs_q        <= t[WIDTH-1] ? ('0 - t) : t;
            neg_q        <= n[WIDTH-1] ^ t[WIDTH-1];
            cnt_q        <= '0;
            state        <= go_div_c ? DIV : COMMIT;
          end
        end
        DIV: begin
          rem_q <= rem_nxt_c;
          quo_q <= quo_nxt_c;
          if (cnt_q == CW'(WIDTH - 1)) begin
            bus.pop   <= 1'b1;
            bus.write <= 1'b1;
            bus.value <= neg_q ? ('0 - quo_nxt_c) : quo_nxt_c;
            state     <= COMMIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        COMMIT: begin
          bus.push     <= 1'b0;
          bus.pop      <= 1'b0;
          bus.write    <= 1'b0;
          bus.op_ready <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_executor.sv
// Directed self-checking bench for stack_executor.
module tb_stack_executor;
  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   accepts;

  stack_executor_if #(.WIDTH(32)) bus ();

  stack_executor #(.WIDTH(32), .DEPTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (bus.op_valid && bus.op_ready) accepts++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_stack(input logic [31:0] nx, input logic [31:0] tp, input logic [5:0] cnt);
    bus.stack_next  = nx;
    bus.stack_top   = tp;
    bus.stack_count = cnt;
  endtask

  // Present one request; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] code, input logic [3:0] dig);
    @(negedge clock);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.digit    = dig;
    @(posedge clock);
    #1;
    bus.op_valid = 1'b0;
  endtask

  // Checks the COMMIT cycle, then that op_ready returns after one cycle.
  task automatic expect_commit(input string tag, input logic [2:0] strb,
                               input logic chk_v, input logic [31:0] v,
                               input logic [1:0] e);
    check({tag, "_strobes"}, {29'd0, bus.push, bus.pop, bus.write}, {29'd0, strb});
    check({tag, "_ready_low"}, {31'd0, bus.op_ready}, 32'd0);
    check({tag, "_error"}, {30'd0, bus.error}, {30'd0, e});
    if (chk_v) check({tag, "_value"}, bus.value, v);
    @(posedge clock);
    #1;
    check({tag, "_ready_back"}, {31'd0, bus.op_ready}, 32'd1);
    check({tag, "_idle_strobes"}, {29'd0, bus.push, bus.pop, bus.write}, 32'd0);
  endtask

  // Runs a DIV already accepted; returns cycles op_ready was low.
  task automatic run_div(output int low, output logic [2:0] strb, output logic [31:0] v,
                         output logic [1:0] e);
    low  = 0;
    strb = 3'b000;
    v    = 32'd0;
    e    = 2'b00;
    while (!bus.op_ready && low < 100) begin
      if (bus.pop || bus.write || bus.push) begin
        strb = {bus.push, bus.pop, bus.write};
        v    = bus.value;
        e    = bus.error;
      end
      low++;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int          low;
    int          strobe_cycles;
    logic [2:0]  s;
    logic [31:0] v;
    logic [1:0]  e;
    total = 0;
    bad = 0;
    accepts = 0;
    reset = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code = 4'd0;
    bus.digit = 4'd0;
    set_stack(32'd0, 32'd0, 6'd1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_ready", {31'd0, bus.op_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_strobes", {29'd0, bus.push, bus.pop, bus.write}, 32'd0);
    check("rst_value", bus.value, 32'd0);
    check("rst_error", {30'd0, bus.error}, 32'd0);

    // Digit entry
    set_stack(32'd0, 32'd0, 6'd1);
    issue(4'd0, 4'd4);
    check("dig4_busy", {31'd0, bus.busy}, 32'd1);
    expect_commit("dig4", 3'b001, 1'b1, 32'd4, 2'b00);
    set_stack(32'd0, 32'd4, 6'd1);
    issue(4'd0, 4'd2);
    expect_commit("dig42", 3'b001, 1'b1, 32'd42, 2'b00);
    set_stack(32'd0, 32'hFFFF_FFFB, 6'd1);
    issue(4'd0, 4'd3);
    expect_commit("dig_neg", 3'b001, 1'b1, 32'hFFFF_FFCB, 2'b00);

    // Arithmetic
    set_stack(32'd7, 32'd5, 6'd2);
    issue(4'd3, 4'd0);
    expect_commit("sub", 3'b011, 1'b1, 32'd2, 2'b00);
    set_stack(32'd3, 32'd4, 6'd2);
    issue(4'd2, 4'd0);
    expect_commit("add", 3'b011, 1'b1, 32'd7, 2'b00);
    set_stack(32'hFFFF_FFFD, 32'd4, 6'd2);
    issue(4'd4, 4'd0);
    expect_commit("mul", 3'b011, 1'b1, 32'hFFFF_FFF4, 2'b00);
    set_stack(32'd0, 32'd5, 6'd1);
    issue(4'd6, 4'd0);
    expect_commit("neg", 3'b001, 1'b1, 32'hFFFF_FFFB, 2'b00);
    set_stack(32'd1, 32'd2, 6'd2);
    issue(4'd7, 4'd0);
    expect_commit("drop", 3'b010, 1'b0, 32'd0, 2'b00);
    set_stack(32'd0, 32'd99, 6'd1);
    issue(4'd8, 4'd0);
    expect_commit("clear", 3'b001, 1'b1, 32'd0, 2'b00);
    set_stack(32'd1, 32'd2, 6'd3);
    issue(4'd1, 4'd0);
    expect_commit("enter", 3'b100, 1'b0, 32'd0, 2'b00);

    // Division
    set_stack(32'hFFFF_FFF9, 32'd2, 6'd2);
    issue(4'd5, 4'd0);
    run_div(low, s, v, e);
    check("div_latency", 32'(low), 32'd33);
    check("div_strobes", {29'd0, s}, 32'b011);
    check("div_value", v, 32'hFFFF_FFFD);
    check("div_error", {30'd0, e}, 32'd0);
    set_stack(32'h8000_0000, 32'hFFFF_FFFF, 6'd2);
    issue(4'd5, 4'd0);
    run_div(low, s, v, e);
    check("divmin_strobes", {29'd0, s}, 32'b011);
    check("divmin_value", v, 32'h8000_0000);
    check("divmin_error", {30'd0, e}, 32'd0);

    // Error cases
    set_stack(32'd9, 32'd0, 6'd2);
    issue(4'd5, 4'd0);
    expect_commit("div0", 3'b000, 1'b0, 32'd0, 2'b11);
    check("div0_err_hold", {30'd0, bus.error}, 32'd3);
    set_stack(32'd0, 32'd5, 6'd1);
    issue(4'd2, 4'd0);
    expect_commit("add_under", 3'b000, 1'b0, 32'd0, 2'b01);
    issue(4'd7, 4'd0);
    expect_commit("drop_under", 3'b000, 1'b0, 32'd0, 2'b01);
    issue(4'd5, 4'd0);
    expect_commit("div_under", 3'b000, 1'b0, 32'd0, 2'b01);
    set_stack(32'd1, 32'd2, 6'd32);
    issue(4'd1, 4'd0);
    expect_commit("enter_full", 3'b000, 1'b0, 32'd0, 2'b10);
    issue(4'd12, 4'd0);
    expect_commit("illegal", 3'b000, 1'b0, 32'd0, 2'b11);
    issue(4'd0, 4'd10);
    expect_commit("digit_bad", 3'b000, 1'b0, 32'd0, 2'b11);
    set_stack(32'd0, 32'd0, 6'd1);
    issue(4'd8, 4'd0);
    expect_commit("err_clear", 3'b001, 1'b1, 32'd0, 2'b00);

    // Reset in the middle of a division
    set_stack(32'hFFFF_FFF9, 32'd2, 6'd2);
    issue(4'd5, 4'd0);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    check("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_strobes", {29'd0, bus.push, bus.pop, bus.write}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_value", bus.value, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    strobe_cycles = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.push || bus.pop || bus.write) strobe_cycles++;
    end
    check("abort_no_cmd", 32'(strobe_cycles), 32'd0);
    check("abort_ready", {31'd0, bus.op_ready}, 32'd1);

    // Request held while busy is taken exactly once
    accepts = 0;
    set_stack(32'd10, 32'd3, 6'd2);
    issue(4'd5, 4'd0);
    bus.op_valid = 1'b1;
    bus.op_code  = 4'd2;
    run_div(low, s, v, e);
    check("hold_div_value", v, 32'd3);
    check("hold_div_strobes", {29'd0, s}, 32'b011);
    @(posedge clock);
    #1;
    bus.op_valid = 1'b0;
    expect_commit("hold_add", 3'b011, 1'b1, 32'd13, 2'b00);
    repeat (5) @(posedge clock);
    #1;
    check("hold_accepts", 32'(accepts), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
